jt49_nch: RTL and testbench
===========================

JT49_NCH -- requirements
Module: jt49_nch

Interface
REQ-001 Parameter CH, default 3: number of tone channels, legal range 1..8.
REQ-002 Parameter PW, default 12: tone period width in bits, legal range 8..16.
REQ-003 Derived constant AW = clog2(4*CH), minimum 2: register address width; SW = 8+clog2(CH+1): mix output width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 clk_en  in  1  mixer/sequencer enable.
REQ-007 cen16  in  1  tone-divider tick, qualified internally by clk_en.
REQ-008 addr  in  AW  register address.
REQ-009 cs_n, wr_n  in  1 each  active-low chip select and write strobe.
REQ-010 din  in  8  write data.
REQ-011 dout  out  8  registered read data.
REQ-012 noise  in  1  shared noise bit.
REQ-013 env  in  5  shared envelope level.
REQ-014 left, right  out  SW each  stereo mix outputs.
REQ-015 sample  out  1  one-clk pulse when left/right update.

Function
REQ-016 Register map per channel c: 4c+0 period[7:0]; 4c+1 period[PW-1:8]; 4c+2 bits [3:0] vol, bit 4 use_env; 4c+3 bit 0 tone_off, bit 1 noise_off, bit 2 panL, bit 3 panR.
REQ-017 Write: when cs_n=0 and wr_n=0, reg[addr] <= din on every clk, independent of clk_en; addresses >= 4*CH are ignored.
REQ-018 Read: dout <= reg[addr] & mask every clk; masks: +0 8'hff, +1 low (PW-8) bits, +2 8'h1f, +3 8'h0f; unmapped addresses read 8'h00.
REQ-019 Same-cycle write and read of one address: dout returns the old value; new value visible one clk later.
REQ-020 Tone divider per channel: on clk_en&cen16, cnt+1 >= eff_period -> cnt <= 0, tone bit toggles; else cnt <= cnt+1; eff_period = period, or 1 when period = 0.
REQ-021 Period reduced below current cnt: divider wraps and toggles on the next tick; no stall.
REQ-022 Gate per channel: mix = (tone | tone_off) & (noise | noise_off).
REQ-023 Log level per channel: mix=0 -> 0; else use_env ? env : {vol, vol[3]}.
REQ-024 Log-to-linear: 32-entry 8-bit table, entry 0 = 0, entry 31 = 255, monotonic non-decreasing, combinational lookup.
REQ-025 Sequencer: slot counter 0..CH, advances by one per clk_en, wraps CH -> 0.
REQ-026 Slot s<CH: accL += lin(s) if panL(s); accR += lin(s) if panR(s); both pan bits 0 -> channel muted.
REQ-027 Slot CH: left <= accL, right <= accR, both accumulators cleared, sample = 1 for that clk only.
REQ-028 Accumulator width SW; no overflow possible (CH*255 < 2^SW).
REQ-029 Register or level change takes effect at that channel's next slot; mix frame latency CH+1 clk_en cycles.
REQ-030 clk_en=0 freezes dividers, sequencer, accumulators and outputs; sample stays 0.

Reset
REQ-031 rst_n=0 sampled at clk: all registers, counters, tone bits, slot counter, accumulators cleared; dout, left, right = 0; sample = 0.
REQ-032 Reset mid-frame discards the partial sum; first frame after release starts at slot 0.
REQ-033 Writes presented during reset are dropped.

Structure
REQ-034 Shared package jt49_nch_pkg holds the 32-entry linear table, the register offset constants (+0..+3) and the mask constants.
REQ-035 One sub-module jt49_nch_tone (PW-bit divider, ports clk, rst_n, cen, period, tone), instantiated CH times via generate.

Verification
REQ-036 CH=3: ch0 period 0x001, vol 0xF, panL=1, tone_off=1, noise_off=1 -> left = 255, right = 0, sample every 4 clk_en.
REQ-037 CH=3: all channels vol 0xF, both pans, tone/noise off -> left = right = 765; CH=8 same setup -> 2040.
REQ-038 Period 0x000 vs 0x001, clk_en=cen16=1: both toggle tone every tick; period 0x010 toggles every 16 ticks.
REQ-039 Write 0xFF to address 4c+3, read back -> 8'h0f; read unmapped address 4*CH -> 8'h00; same-cycle write/read returns the old value.
REQ-040 use_env=1, env sweeps 0..31 -> left tracks the table value of env at each frame, 0 at env=0.
REQ-041 Assert rst_n=0 at slot 1 of an active frame -> next clk all outputs 0; after release, first sample pulse after CH+1 clk_en with correct sum.

Source files
------------

// File: rtl/jt49_nch_pkg.sv
// Shared constants for the multi-channel tone mixer: register offsets,
// read-back masks and the 5-bit log to 8-bit linear volume table.
package jt49_nch_pkg;

    localparam int OFF_PER_LO = 0;
    localparam int OFF_PER_HI = 1;
    localparam int OFF_LEVEL  = 2;
    localparam int OFF_SWITCH = 3;

    localparam logic [7:0] MASK_PER_LO = 8'hff;
    localparam logic [7:0] MASK_LEVEL  = 8'h1f;
    localparam logic [7:0] MASK_SWITCH = 8'h0f;

    localparam logic [7:0] LIN_TABLE [32] = '{
        8'd0,   8'd1,   8'd1,   8'd1,   8'd2,   8'd2,   8'd3,   8'd3,
        8'd4,   8'd5,   8'd6,   8'd7,   8'd9,   8'd11,  8'd13,  8'd15,
        8'd18,  8'd22,  8'd26,  8'd31,  8'd37,  8'd45,  8'd53,  8'd63,
        8'd75,  8'd90,  8'd106, 8'd127, 8'd151, 8'd180, 8'd212, 8'd255
    };

    function automatic int addr_width(input int ch);
        return ($clog2(4 * ch) < 2) ? 2 : $clog2(4 * ch);
    endfunction

    // Upper period byte only holds the PW-8 bits above the low byte.
    function automatic logic [7:0] per_hi_mask(input int pw);
        return 8'hff >> (16 - pw);
    endfunction

    function automatic logic [7:0] read_mask(input logic [1:0] off, input int pw);
        case (int'(off))
            OFF_PER_LO: return MASK_PER_LO;
            OFF_PER_HI: return per_hi_mask(pw);
            OFF_LEVEL:  return MASK_LEVEL;
            default:    return MASK_SWITCH;
        endcase
    endfunction

    function automatic logic [7:0] lin(input logic [4:0] level);
        return LIN_TABLE[level];
    endfunction

endpackage

// File: rtl/jt49_nch_tone.sv
// Square-wave tone divider: toggles its output every max(period,1) ticks.
module jt49_nch_tone #(
    parameter int PW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [PW-1:0] period,
    output logic          tone
);

    logic [PW-1:0] cnt;
    logic [PW:0]   cnt_inc;
    logic [PW:0]   eff_period;

    // One extra bit so the compare never wraps; ">=" lets a shrunken period
    // restart the count on the next tick instead of stalling.
    assign cnt_inc    = {1'b0, cnt} + (PW+1)'(1);
    assign eff_period = (period == '0) ? (PW+1)'(1) : {1'b0, period};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (cen) begin
            if (cnt_inc >= eff_period) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt <= cnt_inc[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/jt49_nch.sv
// CH-channel tone generator with per-channel gating, log volume and stereo
// panning, mixed by a time-multiplexed accumulator one slot per clk_en.
module jt49_nch
    import jt49_nch_pkg::*;
#(
    parameter  int CH = 3,
    parameter  int PW = 12,
    localparam int AW = addr_width(CH),
    localparam int SW = 8 + $clog2(CH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          cen16,
    input  logic [AW-1:0] addr,
    input  logic          cs_n,
    input  logic          wr_n,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    input  logic          noise,
    input  logic [4:0]    env,
    output logic [SW-1:0] left,
    output logic [SW-1:0] right,
    output logic          sample
);

    localparam int NREG = 4 * CH;
    localparam int SLW  = $clog2(CH + 1);

    logic [7:0]    regs [NREG];
    logic          mapped;
    logic          tick;
    logic [CH-1:0] tone;
    logic [CH-1:0] mix;
    logic [CH-1:0] pan_l;
    logic [CH-1:0] pan_r;
    logic [7:0]    lin_lvl [CH];

    assign mapped = int'(addr) < NREG;
    assign tick   = clk_en & cen16;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the register file is small flops, not RAM, so it is cleared
            // with everything else; this also guarantees silence after reset.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            dout <= '0;
        end else begin
            // NOTE: non-blocking here is what makes a same-cycle read return
            // the old contents while the write lands at the same edge.
            if (!cs_n && !wr_n && mapped) regs[addr] <= din;
            dout <= mapped ? (regs[addr] & read_mask(addr[1:0], PW)) : 8'h00;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [PW-1:0] period;
        logic [4:0]    level;

        assign period = PW'({regs[4*c+OFF_PER_HI], regs[4*c+OFF_PER_LO]});

        jt49_nch_tone #(.PW(PW)) u_tone (
            .clk    (clk),
            .rst_n  (rst_n),
            .cen    (tick),
            .period (period),
            .tone   (tone[c])
        );

        assign mix[c]     = (tone[c] | regs[4*c+OFF_SWITCH][0])
                          & (noise   | regs[4*c+OFF_SWITCH][1]);
        assign level      = !mix[c]                  ? 5'd0 :
                            regs[4*c+OFF_LEVEL][4]   ? env  :
                            {regs[4*c+OFF_LEVEL][3:0], regs[4*c+OFF_LEVEL][3]};
        assign lin_lvl[c] = lin(level);
        assign pan_l[c]   = regs[4*c+OFF_SWITCH][2];
        assign pan_r[c]   = regs[4*c+OFF_SWITCH][3];
    end

    logic [SLW-1:0] slot;
    logic [SW-1:0]  acc_l;
    logic [SW-1:0]  acc_r;
    logic [7:0]     cur_lin;
    logic           cur_l;
    logic           cur_r;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        cur_lin = '0;
        cur_l   = 1'b0;
        cur_r   = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (slot == SLW'(c)) begin
                cur_lin = lin_lvl[c];
                cur_l   = pan_l[c];
                cur_r   = pan_r[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot   <= '0;
            acc_l  <= '0;
            acc_r  <= '0;
            left   <= '0;
            right  <= '0;
            sample <= 1'b0;
        end else begin
            sample <= 1'b0;
            if (clk_en) begin
                if (slot == SLW'(CH)) begin
                    slot   <= '0;
                    left   <= acc_l;
                    right  <= acc_r;
                    acc_l  <= '0;
                    acc_r  <= '0;
                    sample <= 1'b1;
                end else begin
                    slot <= slot + SLW'(1);
                    if (cur_l) acc_l <= acc_l + SW'(cur_lin);
                    if (cur_r) acc_r <= acc_r + SW'(cur_lin);
                end
            end
        end
    end

endmodule

// File: tb/tb_jt49_nch.sv
// Directed and randomized checks of jt49_nch (CH=3 and CH=8) against a
// frame-level mixing model derived from the register and gating rules.
module tb_jt49_nch;

    localparam int CH  = 3;
    localparam int PW  = 12;
    localparam int AW  = 4;
    localparam int SW  = 10;
    localparam int AW8 = 5;
    localparam int SW8 = 12;

    localparam int LIN_TAB [32] = '{
        0, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7, 9, 11, 13, 15,
        18, 22, 26, 31, 37, 45, 53, 63, 75, 90, 106, 127, 151, 180, 212, 255
    };

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic           clk_en = 1'b0;
    logic           cen16  = 1'b0;
    logic           cs_n   = 1'b1;
    logic           cs8_n  = 1'b1;
    logic           wr_n   = 1'b1;
    logic           noise  = 1'b0;
    logic [AW-1:0]  addr   = '0;
    logic [AW8-1:0] addr8  = '0;
    logic [7:0]     din    = '0;
    logic [4:0]     env    = '0;
    logic [7:0]     dout;
    logic [7:0]     dout8;
    logic [SW-1:0]  left;
    logic [SW-1:0]  right;
    logic [SW8-1:0] left8;
    logic [SW8-1:0] right8;
    logic           sample;
    logic           sample8;

    int n_cmp  = 0;
    int n_fail = 0;
    int rm [16];

    always #5 clk = ~clk;

    jt49_nch #(.CH(CH), .PW(PW)) u_dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cen16(cen16),
        .addr(addr), .cs_n(cs_n), .wr_n(wr_n), .din(din), .dout(dout),
        .noise(noise), .env(env), .left(left), .right(right), .sample(sample)
    );

    jt49_nch #(.CH(8), .PW(PW)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cen16(cen16),
        .addr(addr8), .cs_n(cs8_n), .wr_n(wr_n), .din(din), .dout(dout8),
        .noise(noise), .env(env), .left(left8), .right(right8), .sample(sample8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_all();
        rst_n  = 1'b0;
        clk_en = 1'b0;
        cen16  = 1'b0;
        cs_n   = 1'b1;
        cs8_n  = 1'b1;
        wr_n   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        addr = AW'(a);
        din  = d;
        cs_n = 1'b0;
        wr_n = 1'b0;
        @(negedge clk);
        cs_n = 1'b1;
        wr_n = 1'b1;
    endtask

    task automatic wr8(input int a, input logic [7:0] d);
        addr8 = AW8'(a);
        din   = d;
        cs8_n = 1'b0;
        wr_n  = 1'b0;
        @(negedge clk);
        cs8_n = 1'b1;
        wr_n  = 1'b1;
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        addr = AW'(a);
        @(negedge clk);
        d = dout;
    endtask

    task automatic wait_sample(input bit big, output int clks);
        clks = 0;
        do begin
            @(negedge clk);
            clks++;
        end while (!(big ? sample8 : sample) && clks < 300);
        if (!(big ? sample8 : sample)) begin
            n_cmp++;
            n_fail++;
            $error("FAIL sample_timeout: no pulse within %0d clk", clks);
        end
    endtask

    // The first pulse may close a frame that started before the last change.
    task automatic frame(input bit big, output int l, output int r);
        int clks;
        wait_sample(big, clks);
        wait_sample(big, clks);
        l = big ? int'(left8)  : int'(left);
        r = big ? int'(right8) : int'(right);
    endtask

    function automatic int rd_mask(input int a);
        case (a % 4)
            0:       return 255;
            1:       return (1 << (PW - 8)) - 1;
            2:       return 31;
            default: return 15;
        endcase
    endfunction

    // Expected mix with all tone bits at 0 (dividers never ticked since reset).
    function automatic int exp_mix(input bit right_side);
        int s = 0;
        for (int c = 0; c < CH; c++) begin
            int vol  = rm[4*c+2] & 15;
            int ue   = (rm[4*c+2] >> 4) & 1;
            int sw   = rm[4*c+3];
            bit gate = ((sw & 1) != 0) && (noise || ((sw & 2) != 0));
            int lvl  = !gate ? 0 : (ue != 0) ? int'(env) : vol * 2 + vol / 8;
            int pan  = right_side ? (sw >> 3) & 1 : (sw >> 2) & 1;
            if (pan != 0) s += LIN_TAB[lvl];
        end
        return s;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int l, r, clks, first, second, seen;

        // Reset state, with a write presented during reset that must be dropped.
        @(negedge clk);
        addr = AW'(2);
        din  = 8'h0f;
        cs_n = 1'b0;
        wr_n = 1'b0;
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        wr_n = 1'b1;
        check("rst_dout", dout, 0);
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        check("rst_sample", sample, 0);
        check("rst_left8", left8, 0);
        rst_n = 1'b1;
        rd(2, d);  check("write_in_reset_dropped", d, 0);

        // Register map and read masks.
        wr(3, 8'hff); rd(3, d);  check("mask_switch", d, 8'h0f);
        wr(0, 8'ha5); rd(0, d);  check("mask_per_lo", d, 8'ha5);
        wr(1, 8'hff); rd(1, d);  check("mask_per_hi", d, 8'h0f);
        wr(2, 8'hff); rd(2, d);  check("mask_level", d, 8'h1f);
        wr(12, 8'h55); rd(12, d); check("unmapped_read", d, 0);
        rd(0, d);  check("unmapped_write_no_alias", d, 8'ha5);

        // Same-cycle write and read of one address.
        wr(3, 8'h05);
        addr = AW'(3);
        din  = 8'hff;
        cs_n = 1'b0;
        wr_n = 1'b0;
        @(negedge clk);
        check("same_cycle_old", dout, 8'h05);
        cs_n = 1'b1;
        wr_n = 1'b1;
        @(negedge clk);
        check("same_cycle_new", dout, 8'h0f);

        // Single channel, full volume, left only; frame period and freeze.
        reset_all();
        wr(0, 8'h01); wr(2, 8'h0f); wr(3, 8'h07);
        clk_en = 1'b1;
        frame(0, l, r);
        check("ch0_left", l, 255);
        check("ch0_right", r, 0);
        wait_sample(0, clks);
        check("frame_period", clks, CH + 1);
        first  = -1;
        second = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sample) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            clk_en = ~clk_en;
        end
        check("half_rate_period", second - first, 2 * (CH + 1));
        clk_en = 1'b0;
        seen   = 0;
        repeat (10) begin
            @(negedge clk);
            if (sample) seen++;
        end
        check("freeze_no_sample", seen, 0);
        check("freeze_left_held", left, 255);

        // All channels full on both sides, CH=3 and CH=8.
        reset_all();
        for (int c = 0; c < 3; c++) begin wr(4*c+2, 8'h0f); wr(4*c+3, 8'h0f); end
        for (int c = 0; c < 8; c++) begin wr8(4*c+2, 8'h0f); wr8(4*c+3, 8'h0f); end
        clk_en = 1'b1;
        frame(0, l, r);
        check("all3_left", l, 765);
        check("all3_right", r, 765);
        frame(1, l, r);
        check("all8_left", l, 2040);
        check("all8_right", r, 2040);

        // Tone dividers: period 0 and 1 toggle every tick, 0x010 every 16.
        reset_all();
        wr(4, 8'h01); wr(8, 8'h10); wr(9, 8'h00);
        clk_en = 1'b1;
        cen16  = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            check($sformatf("tone_p0_t%0d", n),  u_dut.g_ch[0].u_tone.tone, n % 2);
            check($sformatf("tone_p1_t%0d", n),  u_dut.g_ch[1].u_tone.tone, n % 2);
            check($sformatf("tone_p16_t%0d", n), u_dut.g_ch[2].u_tone.tone, (n / 16) % 2);
        end

        // Envelope sweep on channel 0.
        reset_all();
        wr(2, 8'h10); wr(3, 8'h07);
        clk_en = 1'b1;
        for (int e = 0; e < 32; e++) begin
            env = 5'(e);
            frame(0, l, r);
            check($sformatf("env_%0d_left", e), l, LIN_TAB[e]);
        end
        check("env_right", r, 0);

        // Reset at slot 1 of an active frame (channel 0 at env 31 = 255 left).
        wait_sample(0, clks);
        @(negedge clk);
        rst_n  = 1'b0;
        clk_en = 1'b0;
        @(negedge clk);
        check("midreset_left", left, 0);
        check("midreset_right", right, 0);
        check("midreset_sample", sample, 0);
        check("midreset_dout", dout, 0);
        rst_n = 1'b1;
        wr(6, 8'h0f); wr(7, 8'h0b);
        clk_en = 1'b1;
        wait_sample(0, clks);
        check("post_reset_latency", clks, CH + 1);
        check("post_reset_left", left, 0);
        check("post_reset_right", right, 255);

        // Randomized configurations against the mixing model.
        reset_all();
        clk_en = 1'b1;
        for (int it = 0; it < 20; it++) begin
            int ra;
            for (int a = 0; a < 4 * CH; a++) begin
                rm[a] = int'(8'($urandom));
                wr(a, 8'(rm[a]));
            end
            noise = 1'($urandom);
            env   = 5'($urandom);
            frame(0, l, r);
            check($sformatf("rand%0d_left", it), l, exp_mix(1'b0));
            check($sformatf("rand%0d_right", it), r, exp_mix(1'b1));
            ra = int'($urandom_range(0, 15));
            rd(ra, d);
            check($sformatf("rand%0d_rd%0d", it, ra), d, (ra < 4 * CH) ? (rm[ra] & rd_mask(ra)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
